i2c_slave_responder: RTL

- I2C target (slave) responder: the far end of the bus driven by our I2C master.
- Oversamples the bus SCL/SDA pins with the 50 MHz system clock, detects START/STOP, matches a 7-bit address, and ACKs it.
- Receives write bytes onto a byte-wide strobe interface; serialises read bytes from a byte-wide load interface.
- SDA is open-drain: the block only ever pulls it low.

---
 rtl/i2c_slave_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target responder: oversamples SCL/SDA, matches a 7-bit address, receives
// write bytes onto a strobe interface and serialises read bytes from a load interface.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy,
    output logic       rw,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX_BYTE  = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX_BYTE  = 3'd5,
        S_TX_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_prev, sda_prev;
    logic scl, sda;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift_reg, shift_n;
    logic       sda_oe_n, rx_valid_n, busy_n, rw_n;
    logic [7:0] rx_data_n;

    // Synchronisers and edge history idle at the released-bus level (1).
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl;
            sda_prev <= sda;
        end
    end

    assign scl        = scl_sync[SYNC_STAGES-1];
    assign sda        = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl & ~scl_prev;
    assign scl_fall   = ~scl & scl_prev;
    assign start_cond = scl & scl_prev & sda_prev & ~sda;
    assign stop_cond  = scl & scl_prev & ~sda_prev & sda;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            sda_oe    <= sda_oe_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            busy      <= busy_n;
            rw        <= rw_n;
        end
    end

    // rx_valid is a registered one-cycle strobe with rx_data; tx_load is high in
    // exactly the cycle whose closing edge captures tx_data (no back-pressure either way).
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift_reg;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        busy_n     = busy;
        rw_n       = rw;
        tx_load    = 1'b0;

        if (start_cond) begin
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = 3'd0;
            state_n   = S_ADDR;
        end else if (stop_cond) begin
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = 3'd0;
            state_n   = S_IDLE;
        end else begin
            case (state)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift_reg[6:0], sda};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shift_reg[6:0] == SLAVE_ADDR) begin
                                rw_n    = sda;
                                state_n = S_ADDR_ACK;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end
                    end
                end
                // sda_oe doubles as the phase flag of the two-falling-edge ACK slot.
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                        end else if (!rw) begin
                            sda_oe_n = 1'b0;
                            state_n  = S_RX_BYTE;
                        end else begin
                            tx_load   = 1'b1;
                            shift_n   = tx_data;
                            sda_oe_n  = ~tx_data[7];
                            bit_cnt_n = 3'd0;
                            state_n   = S_TX_BYTE;
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_n   = {shift_reg[6:0], sda};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = {shift_reg[6:0], sda};
                            rx_valid_n = 1'b1;
                            state_n    = S_RX_ACK;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = S_RX_BYTE;
                        end
                    end
                end
                S_TX_BYTE: begin
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            sda_oe_n = 1'b0;
                            state_n  = S_TX_ACK;
                        end else begin
                            shift_n  = {shift_reg[6:0], 1'b0};
                            sda_oe_n = ~shift_reg[6];
                        end
                    end
                end
                // A falling edge here always follows an ACKed rising edge; NACK leaves first.
                S_TX_ACK: begin
                    if (scl_rise && sda) begin
                        busy_n  = 1'b0;
                        state_n = S_IGNORE;
                    end else if (scl_fall) begin
                        tx_load   = 1'b1;
                        shift_n   = tx_data;
                        sda_oe_n  = ~tx_data[7];
                        bit_cnt_n = 3'd0;
                        state_n   = S_TX_BYTE;
                    end
                end
                S_IGNORE: begin
                    sda_oe_n = 1'b0;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
